// File: rtl/skid_buffer_pkg.sv
// skid_buffer_pkg: state encoding and occupancy constants for the skid buffer
package skid_buffer_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b10} state_t;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY = 2'd1;
  localparam logic [1:0] OCC_FULL = 2'd2;
endpackage

// File: rtl/skid_buffer_reg.sv
// skid_buffer_reg: enabled register with synchronous active-high reset
module skid_buffer_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RST;
    else if (en) q <= d;
endmodule

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready slice; in_rdy and out_vld decode from state flops only
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int W = 32,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  input  logic         out_rdy,
  output logic [1:0]   occ
);
  logic [1:0] state_q;
  state_t state, nxt;
  logic [W-1:0] skid, out_nxt;
  logic push, pop, out_en, skid_en;

  assign state = state_t'(state_q);
  assign in_rdy = state != FULL;
  assign out_vld = state != EMPTY;
  assign occ = state == FULL ? OCC_FULL : state == BUSY ? OCC_BUSY : OCC_EMPTY;
  assign push = in_vld & in_rdy;
  assign pop = out_vld & out_rdy;

  always_comb begin
    nxt = EMPTY;
    out_en = 1'b0;
    skid_en = 1'b0;
    out_nxt = in_data;
    case (state)
      EMPTY: begin
        nxt = push ? BUSY : EMPTY;
        out_en = push;
      end
      BUSY: begin
        nxt = push & !pop ? FULL : pop & !push ? EMPTY : BUSY;
        out_en = push & pop;
        skid_en = push & !pop;
      end
      FULL: begin
        nxt = pop ? BUSY : FULL;
        out_en = pop;
        out_nxt = skid;
      end
      default: nxt = EMPTY;
    endcase
  end

  skid_buffer_reg #(.W(2), .RST(EMPTY)) u_state (
    .clk(clk), .rst(rst), .en(1'b1), .d(nxt), .q(state_q)
  );
  skid_buffer_reg #(.W(W), .RST(RST)) u_out (
    .clk(clk), .rst(rst), .en(out_en), .d(out_nxt), .q(out_data)
  );
  skid_buffer_reg #(.W(W), .RST(RST)) u_skid (
    .clk(clk), .rst(rst), .en(skid_en), .d(in_data), .q(skid)
  );
endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed and randomized checks of skid_buffer against a queue model
module tb_skid_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_vld = 1'b0;
  logic [7:0] in_data = '0;
  logic out_rdy = 1'b0;
  logic in_rdy, out_vld;
  logic [7:0] out_data;
  logic [1:0] occ;
  int checks = 0;
  int errs = 0;
  logic [7:0] q[$];
  logic [7:0] mdata = '0;

  skid_buffer #(.W(8), .RST(8'h00)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy), .occ(occ)
  );

  always #5 clk = ~clk;

  // model: the buffer is a FIFO of depth 2; out_data keeps the last head once drained
  task automatic drive(input logic vld, input logic [7:0] d, input logic rdy, output logic pushed);
    logic pu, po;
    in_vld = vld;
    in_data = d;
    out_rdy = rdy;
    pu = vld && q.size() < 2 && !rst;
    po = rdy && q.size() > 0 && !rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mdata = 8'h00;
    end else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(d);
      if (q.size() > 0) mdata = q[0];
    end
    pushed = pu;
    #1;
  endtask

  task automatic test_reset;
    logic p;
    rst = 1'b1;
    drive(1'b1, 8'hFF, 1'b1, p);
    drive(1'b1, 8'hEE, 1'b0, p);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, p);
    checks += 4;
    if (in_rdy !== 1'b1) begin errs++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    if (out_vld !== 1'b0) begin errs++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    if (occ !== 2'd0) begin errs++; $display("FAIL reset_occ got %0d want 0", occ); end
    if (out_data !== 8'h00) begin errs++; $display("FAIL reset_out_data got %h want 00", out_data); end
  endtask

  task automatic test_stream;
    logic p;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b1, p);
      checks++;
      if (out_data !== 8'(i) || out_vld !== 1'b1 || occ !== 2'd1 || in_rdy !== 1'b1) begin
        errs++;
        $display("FAIL stream beat %0d got data=%h vld=%b occ=%0d rdy=%b want data=%h vld=1 occ=1 rdy=1",
                 i, out_data, out_vld, occ, in_rdy, 8'(i));
      end
    end
    drive(1'b0, 8'h00, 1'b1, p);
    checks++;
    if (out_vld !== 1'b0) begin errs++; $display("FAIL stream_drain out_vld got %b want 0", out_vld); end
  endtask

  task automatic test_stall_fill;
    logic p;
    drive(1'b1, 8'hA5, 1'b0, p);
    drive(1'b1, 8'h5A, 1'b0, p);
    checks++;
    if (occ !== 2'd2 || in_rdy !== 1'b0 || out_data !== 8'hA5 || out_vld !== 1'b1) begin
      errs++;
      $display("FAIL stall_full got occ=%0d rdy=%b data=%h vld=%b want occ=2 rdy=0 data=a5 vld=1", occ, in_rdy, out_data, out_vld);
    end
    drive(1'b1, 8'h77, 1'b0, p);
    checks++;
    if (occ !== 2'd2 || out_data !== 8'hA5) begin
      errs++;
      $display("FAIL stall_hold got occ=%0d data=%h want occ=2 data=a5", occ, out_data);
    end
    drive(1'b0, 8'h00, 1'b1, p);
    checks++;
    if (out_data !== 8'h5A || occ !== 2'd1 || in_rdy !== 1'b1) begin
      errs++;
      $display("FAIL stall_pop1 got data=%h occ=%0d rdy=%b want data=5a occ=1 rdy=1", out_data, occ, in_rdy);
    end
    drive(1'b0, 8'h00, 1'b1, p);
    checks++;
    if (out_vld !== 1'b0 || occ !== 2'd0) begin
      errs++;
      $display("FAIL stall_pop2 got vld=%b occ=%0d want vld=0 occ=0", out_vld, occ);
    end
  endtask

  task automatic test_simul_busy;
    logic p;
    drive(1'b1, 8'h11, 1'b0, p);
    checks++;
    if (out_data !== 8'h11 || occ !== 2'd1) begin
      errs++;
      $display("FAIL simul_load got data=%h occ=%0d want data=11 occ=1", out_data, occ);
    end
    drive(1'b1, 8'h22, 1'b1, p);
    checks++;
    if (out_data !== 8'h22 || occ !== 2'd1 || in_rdy !== 1'b1) begin
      errs++;
      $display("FAIL simul_swap got data=%h occ=%0d rdy=%b want data=22 occ=1 rdy=1", out_data, occ, in_rdy);
    end
    drive(1'b0, 8'h00, 1'b1, p);
  endtask

  task automatic test_random;
    logic p, v, r;
    logic [7:0] nxt_in = 8'h00;
    logic [7:0] exp_out = 8'h00;
    int got = 0;
    int pushes = 0;
    int pops = 0;
    int cyc = 0;
    while (got < 10000 && cyc < 40000) begin
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 3) != 0;
      in_vld = v;
      out_rdy = r;
      if (out_vld && out_rdy) begin
        checks++;
        if (out_data !== exp_out) begin
          errs++;
          $display("FAIL rand_order beat %0d got %h want %h", got, out_data, exp_out);
        end
        exp_out++;
        got++;
        pops++;
      end
      if (in_vld && in_rdy) pushes++;
      drive(v, nxt_in, r, p);
      if (p) nxt_in++;
      cyc++;
      checks++;
      if (in_rdy !== (q.size() < 2) || out_vld !== (q.size() > 0) || occ !== 2'(q.size())
          || out_data !== mdata || int'(occ) != pushes - pops) begin
        errs++;
        $display("FAIL rand_state cyc %0d got rdy=%b vld=%b occ=%0d data=%h want rdy=%b vld=%b occ=%0d data=%h net=%0d",
                 cyc, in_rdy, out_vld, occ, out_data, q.size() < 2, q.size() > 0, q.size(), mdata, pushes - pops);
      end
    end
    checks++;
    if (got < 10000) begin errs++; $display("FAIL rand_timeout got %0d beats want 10000", got); end
    while (q.size() > 0) drive(1'b0, 8'h00, 1'b1, p);
  endtask

  task automatic test_reset_full;
    logic p;
    drive(1'b1, 8'hC3, 1'b0, p);
    drive(1'b1, 8'h3C, 1'b0, p);
    checks++;
    if (occ !== 2'd2) begin errs++; $display("FAIL rstfull_fill occ got %0d want 2", occ); end
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1, p);
    rst = 1'b0;
    checks++;
    if (occ !== 2'd0 || out_vld !== 1'b0 || out_data !== 8'h00 || in_rdy !== 1'b1) begin
      errs++;
      $display("FAIL rstfull_clear got occ=%0d vld=%b data=%h rdy=%b want occ=0 vld=0 data=00 rdy=1", occ, out_vld, out_data, in_rdy);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1, p);
      checks++;
      if (out_vld !== 1'b0) begin errs++; $display("FAIL rstfull_emit cyc %0d out_vld got %b want 0", i, out_vld); end
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall_fill;
    test_simul_busy;
    test_random;
    test_reset_full;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Two-entry valid/ready register slice at the consuming end of a registered datapath.
- Breaks the combinational ready path between producer and consumer: in_rdy and out_vld are driven only from flops.
- Sustains full throughput (one beat per cycle) with zero bubbles. Preserves order, and never drops or duplicates a beat.
- Instantiated wherever a pipeline stage must accept backpressure from downstream.

Parameters:
- W, 32, payload width in bits (W >= 1).
- RST, '0 (W bits), reset value of out_data and the skid register.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_vld  input  1  producer beat valid.
- in_data  input  W  producer payload.
- in_rdy  output  1  buffer can accept a beat this cycle; decoded from state flops only.
- out_vld  output  1  out_data holds a valid beat; decoded from state flops only.
- out_data  output  W  head-of-buffer payload, direct flop output.
- out_rdy  input  1  consumer accepts the beat.
- occ  output  2  current occupancy, 0..2, for debug and performance counters.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1, all state returns to reset values on the next posedge.
- Reset values:
  - state=EMPTY, so in_rdy=1, out_vld=0, occ=0.
  - out_data=RST, skid=RST.
- Handshakes:
  - push = in_vld & in_rdy.
  - pop = out_vld & out_rdy.
  - Beats presented while rst=1 are ignored.
- Latency: a beat pushed in cycle N appears on out_data with out_vld=1 in cycle N+1 when the buffer was EMPTY, or when it was BUSY with a simultaneous pop.
- State machine and transitions:
  - EMPTY:
    - push -> BUSY, out_data<=in_data.
    - no push -> stay in EMPTY.
  - BUSY (1 entry, held in out_data):
    - push & pop -> BUSY, out_data<=in_data.
    - push & !pop -> FULL, skid<=in_data, out_data unchanged.
    - pop & !push -> EMPTY.
    - neither -> hold.
  - FULL (2 entries, oldest in out_data):
    - in_rdy=0, so no push is possible.
    - pop -> BUSY, out_data<=skid.
    - no pop -> hold both registers.
  - Illegal state encoding -> EMPTY on the next cycle (defensive default).
- Decodes:
  - in_rdy = (state != FULL).
  - out_vld = (state != EMPTY).
  - occ = {FULL, BUSY} encoded as 0/1/2.
- Stability:
  - out_data and out_vld stay stable while out_vld=1 and out_rdy=0.
  - The buffer does not depend on in_vld staying asserted; a producer may drop in_vld at any time.
- Data-only behaviour: skid and out_data update only on the transitions listed above; otherwise they hold. Payload is never modified.
- Reset mid-operation: any held beats are discarded. out_vld falls in the cycle after the reset edge and no partial beat is emitted.
- Assertions (verification only):
  - out_data stable under a stall.
  - No push while FULL.
  - occ equals pushes minus pops since reset.

Decomposition:
- skid_buffer_pkg:
  - state_t enum logic [1:0] {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
  - Occupancy constants OCC_EMPTY=0, OCC_BUSY=1, OCC_FULL=2.
- No further sub-module is natural. Build state, out_data and skid from the team's standard synchronous-reset register primitives, with next-state logic in one always_comb block.

Test Plan (W=8):
- Reset -> in_rdy=1, out_vld=0, occ=0, out_data=8'h00 on the first cycle after rst deasserts.
- Streaming: out_rdy=1, push 8'h01..8'h10 on consecutive cycles -> out_data 8'h01..8'h10 on consecutive cycles, each one cycle after its push; occ stays 1; no bubbles.
- Stall fill: push 8'hA5, then 8'h5A with out_rdy=0 -> occ=2, in_rdy=0, out_data=8'hA5 held. Then out_rdy=1 for 2 cycles -> out_data shows 8'hA5, then 8'h5A, then out_vld=0.
- Simultaneous in BUSY: holding 8'h11, push 8'h22 with out_rdy=1 -> next cycle out_data=8'h22, occ=1, in_rdy=1.
- Random in_vld/out_rdy, 10k beats, incrementing payload -> scoreboard sees all beats in order with no loss or duplicates; no push is ever observed while FULL.
- Reset while FULL (8'hC3, 8'h3C) -> after the reset edge: occ=0, out_vld=0, out_data=RST; neither beat is ever emitted.
